// File: rtl/ddr3_bank_engine_pkg.sv
// Shared types and defaults for the per-bank DDR3 sequencer.
//   ddr3_cmd_t   : command code presented to cmd_gen
//   bank_state_t : bank sequencer state
//   DEF_*        : default geometry and timing values
//   timer_load() : reload value for a look-ahead down-counter
package ddr3_bank_engine_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_ACTIVATE  = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_PRECHARGE = 3'd4
  } ddr3_cmd_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVATING  = 2'd1,
    ACTIVE      = 2'd2,
    PRECHARGING = 2'd3
  } bank_state_t;

  localparam int unsigned DEF_ROW_BITS   = 14;
  localparam int unsigned DEF_COL_BITS   = 10;
  localparam int unsigned DEF_ADDR_WIDTH = 14;

  localparam int unsigned DEF_T_RCD = 6;
  localparam int unsigned DEF_T_RAS = 15;
  localparam int unsigned DEF_T_RP  = 6;
  localparam int unsigned DEF_T_WR  = 6;
  localparam int unsigned DEF_T_RTP = 4;

  // Command offers are registered, so the decision for an offer at event+T
  // is made in cycle event+T-1; loading T-1 lines the look-ahead flag up with it.
  function automatic int unsigned timer_load(input int unsigned t);
    return (t > 0) ? t - 1 : 0;
  endfunction

endpackage

// File: rtl/ddr3_bank_engine_timer.sv
// ddr3_timer: saturating down-counter used for the bank timing constraints.
//   clk, rst_n : clock, synchronous active-low reset (count clears to 0)
//   load       : load value into the counter this cycle
//   value      : reload value
//   zero_next  : counter will read zero in the next cycle (count <= 1)
module ddr3_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero_next
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_next = (cnt <= CNT_W'(1));

endmodule

// File: rtl/ddr3_bank_engine.sv
// ddr3_bank_engine: per-bank DDR3 sequencer between the request arbiter and
// cmd_gen. Tracks the open row and issues ACT/RD/WR/PRE under tRCD, tRAS,
// tRP, tWR and tRTP, with open or closed page policy and a refresh drain.
//   req_valid/req_ready/req_rnw/req_row/req_col : single-entry request port
//   cmd_valid/cmd_ready/cmd_type/cmd_addr       : command handshake to cmd_gen
//   ref_req/ref_ack                             : refresh drain handshake
//   state/busy/open_row_valid/open_row          : status
module ddr3_bank_engine
  import ddr3_bank_engine_pkg::*;
#(
  parameter int          BANK_ID     = 0,
  parameter int unsigned ROW_BITS    = DEF_ROW_BITS,
  parameter int unsigned COL_BITS    = DEF_COL_BITS,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned T_RCD       = DEF_T_RCD,
  parameter int unsigned T_RAS       = DEF_T_RAS,
  parameter int unsigned T_RP        = DEF_T_RP,
  parameter int unsigned T_WR        = DEF_T_WR,
  parameter int unsigned T_RTP       = DEF_T_RTP,
  parameter int unsigned CLOSED_PAGE = 0,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [ROW_BITS-1:0]   req_row,
  input  logic [COL_BITS-1:0]   req_col,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output ddr3_cmd_t             cmd_type,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  ref_req,
  output logic                  ref_ack,
  output bank_state_t           state,
  output logic                  busy,
  output logic                  open_row_valid,
  output logic [ROW_BITS-1:0]   open_row
);

  if (ADDR_WIDTH < ROW_BITS || ADDR_WIDTH < COL_BITS) begin : g_bad_addr
    $error("ddr3_bank_engine: ADDR_WIDTH narrower than row or column");
  end
  if (BANK_ID < 0) begin : g_bad_bank
    $error("ddr3_bank_engine: BANK_ID must be non-negative");
  end

  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(timer_load(T_RCD));
  localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(timer_load(T_RAS));
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(timer_load(T_RP));
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(timer_load(T_WR));
  localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(timer_load(T_RTP));

  logic                pending;
  logic                pend_rnw;
  logic [ROW_BITS-1:0] pend_row;
  logic [COL_BITS-1:0] pend_col;

  logic                req_fire;
  logic                cmd_fire;
  logic                act_fire;
  logic                rw_fire;
  logic                pre_fire;
  logic [CNT_W-1:0]    rec_val;

  // Pending view including a request accepted this cycle, so the first
  // command can be offered in the cycle right after acceptance.
  logic                eff_pend;
  logic                eff_rnw;
  logic [ROW_BITS-1:0] eff_row;
  logic [COL_BITS-1:0] eff_col;

  logic rcd_zn;
  logic ras_zn;
  logic rp_zn;
  logic rec_zn;

  always_comb begin
    req_ready = rst_n && !pending && !ref_req && (state == IDLE || state == ACTIVE);
    req_fire  = req_valid && req_ready;
    cmd_fire  = cmd_valid && cmd_ready;
    act_fire  = cmd_fire && (cmd_type == CMD_ACTIVATE);
    rw_fire   = cmd_fire && (cmd_type == CMD_READ || cmd_type == CMD_WRITE);
    pre_fire  = cmd_fire && (cmd_type == CMD_PRECHARGE);
    rec_val   = (cmd_type == CMD_READ) ? LD_RTP : LD_WR;
    eff_pend  = pending || req_fire;
    eff_rnw   = pending ? pend_rnw : req_rnw;
    eff_row   = pending ? pend_row : req_row;
    eff_col   = pending ? pend_col : req_col;
    ref_ack   = rst_n && ref_req && !pending && (state == IDLE);
    busy      = (state != IDLE) || pending;
  end

  ddr3_timer #(.CNT_W(CNT_W)) u_trcd (
    .clk(clk), .rst_n(rst_n), .load(act_fire), .value(LD_RCD), .zero_next(rcd_zn)
  );
  ddr3_timer #(.CNT_W(CNT_W)) u_tras (
    .clk(clk), .rst_n(rst_n), .load(act_fire), .value(LD_RAS), .zero_next(ras_zn)
  );
  ddr3_timer #(.CNT_W(CNT_W)) u_trp (
    .clk(clk), .rst_n(rst_n), .load(pre_fire), .value(LD_RP), .zero_next(rp_zn)
  );
  ddr3_timer #(.CNT_W(CNT_W)) u_trec (
    .clk(clk), .rst_n(rst_n), .load(rw_fire), .value(rec_val), .zero_next(rec_zn)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cmd_valid      <= 1'b0;
      cmd_type       <= CMD_NOP;
      cmd_addr       <= '0;
      open_row       <= '0;
      open_row_valid <= 1'b0;
      pending        <= 1'b0;
      pend_rnw       <= 1'b0;
      pend_row       <= '0;
      pend_col       <= '0;
    end else begin
      if (req_fire) begin
        pending  <= 1'b1;
        pend_rnw <= req_rnw;
        pend_row <= req_row;
        pend_col <= req_col;
      end

      if (cmd_fire) begin
        // No new offer on a handshake edge: timers reload on this edge and
        // their flags are only meaningful from the next cycle.
        cmd_valid <= 1'b0;
        cmd_type  <= CMD_NOP;
        cmd_addr  <= '0;
        case (cmd_type)
          CMD_ACTIVATE: begin
            open_row       <= pend_row;
            open_row_valid <= 1'b1;
            state          <= ACTIVATING;
          end
          CMD_READ, CMD_WRITE: begin
            pending <= 1'b0;
          end
          CMD_PRECHARGE: begin
            open_row_valid <= 1'b0;
            state          <= PRECHARGING;
          end
          default: ;
        endcase
      end else if (!cmd_valid) begin
        case (state)
          IDLE: begin
            if (eff_pend) begin
              cmd_valid <= 1'b1;
              cmd_type  <= CMD_ACTIVATE;
              cmd_addr  <= ADDR_WIDTH'(eff_row);
            end
          end
          ACTIVATING: begin
            if (rcd_zn) begin
              state     <= ACTIVE;
              cmd_valid <= 1'b1;
              cmd_type  <= pend_rnw ? CMD_READ : CMD_WRITE;
              cmd_addr  <= ADDR_WIDTH'(pend_col);
            end
          end
          ACTIVE: begin
            if (eff_pend && eff_row == open_row) begin
              cmd_valid <= 1'b1;
              cmd_type  <= eff_rnw ? CMD_READ : CMD_WRITE;
              cmd_addr  <= ADDR_WIDTH'(eff_col);
            end else if ((eff_pend || ref_req || CLOSED_PAGE != 0) && ras_zn && rec_zn) begin
              cmd_valid <= 1'b1;
              cmd_type  <= CMD_PRECHARGE;
              cmd_addr  <= '0;
            end
          end
          PRECHARGING: begin
            if (rp_zn) begin
              state <= IDLE;
              if (eff_pend) begin
                cmd_valid <= 1'b1;
                cmd_type  <= CMD_ACTIVATE;
                cmd_addr  <= ADDR_WIDTH'(eff_row);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
